// File: rtl/wallace_if.sv
// rtl/wallace_if.sv - operand/product bundle for the wallace 4x4 multiplier
//
// Signals:
//   A    [3:0] unsigned multiplicand (driven by master)
//   B    [3:0] unsigned multiplier   (driven by master)
//   prod [7:0] registered product    (driven by slave, the multiplier)
interface wallace_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] prod;

  modport master (output A, output B, input prod);
  modport slave  (input A, input B, output prod);
endinterface

// File: rtl/wallace.sv
// rtl/wallace.sv - 4x4 unsigned Wallace-tree multiplier with registered product
//
// Purpose: prod = A * B, one cycle after A/B are presented, one product per cycle.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset, clears prod immediately
//   bus  - wallace_if.slave: A[3:0], B[3:0] in; prod[7:0] out
//
// Reduction schedule (column heights, weight 2^0 .. 2^6):
//   partial products : 1 2 3 4 3 2 1
//   after stage 1    : 1 2 1 3 2 3 1   (fa1 col2, fa2 col3, fa3 col4)
//   after stage 2    : 1 2 1 1 3 1 2   (fa4 col3, fa5 col5)
//   after stage 3    : 1 2 1 1 1 2 2   (fa6 col4)
// The two remaining rows go through a ripple-carry adder.

module wallace_ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

module wallace (
  input  logic       clk,
  input  logic       rst,
  wallace_if.slave   bus
);
  // pp[i][j] = A[j] & B[i], weight 2^(i+j)
  logic [3:0][3:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = bus.A[j] & bus.B[i];
      end
    end
  end

  // Stage 1
  logic s1, c1, s2, c2, s3, c3;
  wallace_fa u_fa1 (.a(pp[0][2]), .b(pp[1][1]), .c(pp[2][0]), .sum(s1), .carry(c1));
  wallace_fa u_fa2 (.a(pp[0][3]), .b(pp[1][2]), .c(pp[2][1]), .sum(s2), .carry(c2));
  wallace_fa u_fa3 (.a(pp[1][3]), .b(pp[2][2]), .c(pp[3][1]), .sum(s3), .carry(c3));

  // Stage 2: column 3 gets pp[3][0] plus the stage-1 carry from column 2
  logic s4, c4, s5, c5;
  wallace_fa u_fa4 (.a(s2),       .b(pp[3][0]), .c(c1), .sum(s4), .carry(c4));
  wallace_fa u_fa5 (.a(pp[2][3]), .b(pp[3][2]), .c(c3), .sum(s5), .carry(c5));

  // Stage 3: column 4 collects its own sum plus carries from both earlier stages
  logic s6, c6;
  wallace_fa u_fa6 (.a(s3), .b(c2), .c(c4), .sum(s6), .carry(c6));

  // Final ripple-carry add of the two rows:
  //   row x: pp00 pp01 s1 s4 s6 s5  pp33
  //   row y:  -   pp10 -  -  -  c6  c5
  logic r1, r2, r3, r4, r5, r6;
  logic k1, k2, k3, k4, k5, k6;
  wallace_ha u_rc1 (.a(pp[0][1]), .b(pp[1][0]),      .sum(r1), .carry(k1));
  wallace_ha u_rc2 (.a(s1),       .b(k1),            .sum(r2), .carry(k2));
  wallace_ha u_rc3 (.a(s4),       .b(k2),            .sum(r3), .carry(k3));
  wallace_ha u_rc4 (.a(s6),       .b(k3),            .sum(r4), .carry(k4));
  wallace_fa u_rc5 (.a(s5),       .b(c6),     .c(k4), .sum(r5), .carry(k5));
  wallace_fa u_rc6 (.a(pp[3][3]), .b(c5),     .c(k5), .sum(r6), .carry(k6));

  // Column 7 holds only the ripple carry k6, so bit 7 is k6 and the carry
  // beyond it is structurally zero and simply not generated.
  logic [7:0] prod_d;
  logic [7:0] prod_q;

  always_comb begin
    prod_d = {k6, r6, r5, r4, r3, r2, r1, pp[0][0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= 8'h00;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign bus.prod = prod_q;
endmodule

// File: tb/tb_wallace.sv
// tb/tb_wallace.sv - self-checking bench for the wallace 4x4 multiplier
module tb_wallace;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  wallace_if bus ();

  wallace dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [7:0] ref_mul(input int a, input int b);
    int p;
    p = a * b;
    return p[7:0];
  endfunction

  // Present operands on the falling edge, then move to just past the next
  // rising edge where the registered product is sampled.
  task automatic apply(input int a, input int b);
    @(negedge clk);
    bus.A = a[3:0];
    bus.B = b[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    bus.A = 4'd15;
    bus.B = 4'd15;
    #1;
    total++;
    if (bus.prod !== 8'h00) begin
      bad++;
      $display("FAIL reset_async_before_clock: got %0h want 00", bus.prod);
    end
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.prod !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold_edge%0d: got %0h want 00", e, bus.prod);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.prod !== ref_mul(15, 15)) begin
      bad++;
      $display("FAIL reset_release: got %0d want %0d", bus.prod, ref_mul(15, 15));
    end
  endtask

  task automatic test_corners();
    int ca [6] = '{0, 15, 1, 0, 7, 15};
    int cb [6] = '{0, 1, 15, 13, 9, 15};
    for (int k = 0; k < 6; k++) begin
      apply(ca[k], cb[k]);
      total++;
      if (bus.prod !== ref_mul(ca[k], cb[k])) begin
        bad++;
        $display("FAIL corner(%0d,%0d): got %0d want %0d", ca[k], cb[k], bus.prod,
                 ref_mul(ca[k], cb[k]));
      end
    end
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256; v++) begin
      apply(v / 16, v % 16);
      $display("t=%0t A=%0d B=%0d prod=%0d", $time, v / 16, v % 16, bus.prod);
      total++;
      if (bus.prod !== ref_mul(v / 16, v % 16)) begin
        bad++;
        $display("FAIL exhaustive(%0d,%0d): got %0d want %0d", v / 16, v % 16, bus.prod,
                 ref_mul(v / 16, v % 16));
      end
    end
  endtask

  task automatic test_random();
    int a;
    int b;
    for (int k = 0; k < 200; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      apply(a, b);
      total++;
      if (bus.prod !== ref_mul(a, b)) begin
        bad++;
        $display("FAIL random(%0d,%0d): got %0d want %0d", a, b, bus.prod, ref_mul(a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    int v;
    for (int k = 0; k < 16; k++) begin
      v = (k % 2 == 0) ? 15 : 0;
      apply(v, v);
      total++;
      if (bus.prod !== ref_mul(v, v)) begin
        bad++;
        $display("FAIL back_to_back%0d: got %0d want %0d", k, bus.prod, ref_mul(v, v));
      end
    end
  endtask

  task automatic test_mid_reset();
    apply(12, 11);
    total++;
    if (bus.prod !== ref_mul(12, 11)) begin
      bad++;
      $display("FAIL mid_reset_pre: got %0d want %0d", bus.prod, ref_mul(12, 11));
    end
    #5;
    rst = 1'b1;
    #1;
    total++;
    if (bus.prod !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_async: got %0h want 00", bus.prod);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus.prod !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_stale: got %0h want 00", bus.prod);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.prod !== ref_mul(12, 11)) begin
      bad++;
      $display("FAIL mid_reset_release: got %0d want %0d", bus.prod, ref_mul(12, 11));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.A = 4'd0;
    bus.B = 4'd0;
    test_reset();
    test_corners();
    test_exhaustive();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
